// File: rtl/mux_arb_pkg.sv
// Shared constants and FSM state type for the round-robin output mux.
// N_REQ : number of requesters
// SEL_W : width of a requester index
package mux_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    // ARB: free round-robin arbitration; LOCK: burst owner fixed at ptr
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage : mux_arb_pkg

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
// Searches i_req upward from i_ptr+1, wrapping after index 3.
// Ports:
//   i_req     : request vector (N_REQ bits)
//   i_ptr     : index of the last granted requester
//   o_gnt_idx : index of the winning requester (0 when none)
//   o_gnt_vld : set when any request is present
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (i_req[SEL_W'(i_ptr + SEL_W'(k))]) begin
                o_gnt_idx = SEL_W'(i_ptr + SEL_W'(k));
                o_gnt_vld = 1'b1;
            end
        end
    end

endmodule : rr_pick4

// File: rtl/mux_rr_arbiter.sv
// Four-input round-robin mux with a single registered output stage.
// Optional burst locking is compiled in with macro MUX_ARB_LOCK_EN.
// Ports:
//   clk                 : clock, rising edge
//   rst                 : asynchronous reset, active low
//   in_valid[3:0]       : per-requester beat present
//   in_data0..in_data3  : per-requester payloads
//   in_last[3:0]        : per-requester end of burst (MUX_ARB_LOCK_EN only)
//   in_ready[3:0]       : combinational accept, one-hot or zero
//   out_valid           : registered beat present
//   out_data            : registered payload
//   out_sel             : index of the requester that sourced out_data
//   out_ready           : downstream accept
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N_REQ-1:0] in_last,
`endif
    output logic [N_REQ-1:0] in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;

    logic             w_free;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_vld;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_gnt_vld;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    assign w_free = !r_out_valid || out_ready;

    rr_pick4 u_pick (
        .i_req     (in_valid),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_pick_idx),
        .o_gnt_vld (w_pick_vld)
    );

    // In LOCK the owner alone may transfer; others wait even if it is idle.
    always_comb begin
        w_gnt_idx = w_pick_idx;
        w_gnt_vld = w_pick_vld;
        if (r_state == LOCK) begin
            w_gnt_idx = r_ptr;
            w_gnt_vld = in_valid[r_ptr];
        end
    end

    // Reset gates the handshake so no beat is accepted while rst is low.
    assign w_xfer   = rst && w_free && w_gnt_vld;
    assign in_ready = w_xfer ? (N_REQ'(1) << w_gnt_idx) : '0;

    // Payload select for the granted requester.
    always_comb begin
        w_sel_data = in_data0;
        case (w_gnt_idx)
            2'd0:    w_sel_data = in_data0;
            2'd1:    w_sel_data = in_data1;
            2'd2:    w_sel_data = in_data2;
            default: w_sel_data = in_data3;
        endcase
    end

    // Next-state logic for burst locking.
    always_comb begin
        w_state_nxt = r_state;
`ifdef MUX_ARB_LOCK_EN
        case (r_state)
            ARB:     if (w_xfer && !in_last[w_gnt_idx]) w_state_nxt = LOCK;
            LOCK:    if (w_xfer && in_last[r_ptr])      w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
`else
        w_state_nxt = ARB;
`endif
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB;
            r_ptr   <= SEL_W'(N_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_ptr <= w_gnt_idx;
            end
        end
    end

    // Output stage: load on transfer, drain when free, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_gnt_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule : mux_rr_arbiter

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed stimulus pushes hand-computed
// beats, a negedge monitor pops and compares each beat the DUT hands off.
// Burst-lock scenario is included when MUX_ARB_LOCK_EN is defined.
module tb_mux_rr_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sel;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [7:0] in_data0, in_data1, in_data2, in_data3;
`ifdef MUX_ARB_LOCK_EN
    logic [3:0] in_last;
`endif
    logic [3:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_sel;
    logic       out_ready;

    beat_t q_exp[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    mux_rr_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
`ifdef MUX_ARB_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the grant on the current inputs, optionally queue the beat, advance.
    task automatic grant(input string name, input logic [3:0] exp_rdy,
                         input bit push, input logic [7:0] d, input logic [1:0] s);
        #1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (push) q_exp.push_back('{data: d, sel: s});
        step();
        if (exp_rdy != 4'b0000) chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Monitor: a beat leaves the DUT at the next edge when valid and ready.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = q_exp.pop_front();
                chk("beat_data", 32'(out_data), 32'(e.data));
                chk("beat_sel",  32'(out_sel),  32'(e.sel));
            end
        end
    end

    // Per-cycle protocol checks.
    logic       prev_hold = 1'b0;
    logic       prev_rst  = 1'b0;
    logic [7:0] prev_data = '0;
    logic [1:0] prev_sel  = '0;
    always @(negedge clk) begin
        chk("in_ready_onehot0", 32'($onehot0(in_ready)), 32'd1);
        if (rst && out_valid && !out_ready)
            chk("no_xfer_when_busy", 32'(in_ready), 32'd0);
        if (prev_hold && prev_rst && rst) begin
            chk("hold_data", 32'(out_data), 32'(prev_data));
            chk("hold_sel",  32'(out_sel),  32'(prev_sel));
        end
        prev_hold = out_valid && !out_ready;
        prev_rst  = rst;
        prev_data = out_data;
        prev_sel  = out_sel;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 4'b1111;
        in_data0  = 8'h00; in_data1 = 8'h00; in_data2 = 8'h00; in_data3 = 8'h00;
        out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        in_last   = 4'b1111;
`endif
        // Reset state
        step(); step();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_sel",   32'(out_sel),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        step();

        // Rotating grants with all requesters valid, no bubbles
        rst = 1'b1;
        in_data0 = 8'h11; in_data1 = 8'h22; in_data2 = 8'h33; in_data3 = 8'h44;
        in_valid = 4'b1111; out_ready = 1'b1;
        grant("rr0", 4'b0001, 1'b1, 8'h11, 2'd0);
        grant("rr1", 4'b0010, 1'b1, 8'h22, 2'd1);
        grant("rr2", 4'b0100, 1'b1, 8'h33, 2'd2);
        grant("rr3", 4'b1000, 1'b1, 8'h44, 2'd3);
        grant("rr4", 4'b0001, 1'b1, 8'h11, 2'd0);
        in_valid = 4'b0000;
        step(); step();
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: beat held stable, nothing accepted while held
        in_valid = 4'b0100; in_data2 = 8'hA5; out_ready = 1'b0;
        grant("bp_load", 4'b0100, 1'b1, 8'hA5, 2'd2);
        in_data2 = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            grant("bp_hold", 4'b0000, 1'b0, 8'h00, 2'd0);
            chk("bp_data", 32'(out_data), 32'hA5);
            chk("bp_sel",  32'(out_sel),  32'd2);
        end
        in_valid = 4'b0000; out_ready = 1'b1;
        step(); step();

        // Wrap search: ptr 2 -> 3, then 3 again, then 0
        in_valid = 4'b1000; in_data3 = 8'hC3;
        grant("wrap_a", 4'b1000, 1'b1, 8'hC3, 2'd3);
        in_data3 = 8'h3C;
        grant("wrap_b", 4'b1000, 1'b1, 8'h3C, 2'd3);
        in_valid = 4'b1001; in_data0 = 8'h0F;
        grant("wrap_c", 4'b0001, 1'b1, 8'h0F, 2'd0);
        in_valid = 4'b0000;
        step(); step();

        // Reset while a beat is held (and locked when enabled): beat discarded
        in_valid = 4'b0010; in_data1 = 8'h77; out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        in_last = 4'b0000;
`endif
        grant("pre_rst", 4'b0010, 1'b0, 8'h00, 2'd0);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        chk("midrst_out_data",  32'(out_data),  32'd0);
        step();
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_data0 = 8'hE0;
`ifdef MUX_ARB_LOCK_EN
        in_last = 4'b1111;
`endif
        grant("post_rst", 4'b0001, 1'b1, 8'hE0, 2'd0);
        in_valid = 4'b0000;
        step(); step();

`ifdef MUX_ARB_LOCK_EN
        // Burst lock: requester 1 owns three beats, requester 2 waits
        in_valid = 4'b0110; in_last = 4'b0000; in_data2 = 8'hC2;
        in_data1 = 8'hB1;
        grant("lock_b1", 4'b0010, 1'b1, 8'hB1, 2'd1);
        in_data1 = 8'hB2;
        grant("lock_b2", 4'b0010, 1'b1, 8'hB2, 2'd1);
        in_valid = 4'b0100;
        grant("lock_gap", 4'b0000, 1'b0, 8'h00, 2'd0);
        in_valid = 4'b0110; in_last = 4'b0010; in_data1 = 8'hB3;
        grant("lock_b3", 4'b0010, 1'b1, 8'hB3, 2'd1);
        in_valid = 4'b0100; in_last = 4'b1111;
        grant("unlock", 4'b0100, 1'b1, 8'hC2, 2'd2);
        in_valid = 4'b0000;
        step(); step();
`endif

        for (int i = 0; i < 20 && q_exp.size() != 0; i++) step();
        chk("scoreboard_empty", 32'(q_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_rr_arbiter

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the data width of all data ports.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; state SHALL clear while rst=0.
REQ-004 in_valid  input  4  bit i set: requester i presents a beat.
REQ-005 in_data0..in_data3  input  WIDTH each  requester payloads.
REQ-006 in_last  input  4  bit i set: end of requester i burst (present only with MUX_ARB_LOCK_EN).
REQ-007 in_ready  output  4  one-hot or zero; bit i set: requester i beat is accepted this cycle.
REQ-008 out_valid  output  1  registered output holds a beat.
REQ-009 out_data  output  WIDTH  registered selected payload.
REQ-010 out_sel  output  2  index of the requester that sourced out_data.
REQ-011 out_ready  input  1  downstream accepts the beat when out_valid=1.

Function
REQ-012 Output register "free" SHALL mean out_valid=0 or out_ready=1.
REQ-013 When free, the block SHALL grant the first valid requester, searching upward cyclically from ptr+1, where ptr is the last granted index.
REQ-014 in_ready SHALL be driven combinationally: only the granted bit is set, and all bits are 0 when the register is not free or no in_valid is set.
REQ-015 A transfer on in_valid[i]&in_ready[i] SHALL load out_data<=in_data_i, out_sel<=i and out_valid<=1 on the next edge: latency 1 cycle, throughput 1 beat/cycle.
REQ-016 With the register free and no transfer, out_valid SHALL go to 0; when not free, out_valid, out_data and out_sel SHALL hold.
REQ-017 ptr SHALL update to i on every transfer and never otherwise; after index 3 the search SHALL wrap to index 0.
REQ-018 A requester that deasserts in_valid before it is granted SHALL lose nothing; no grant is latched.
REQ-019 FSM states: ARB (free arbitration) and LOCK (burst owner fixed); without MUX_ARB_LOCK_EN the FSM SHALL remain in ARB.
REQ-020 ARB->LOCK SHALL occur on a transfer with in_last[i]=0. LOCK->ARB SHALL occur on an owner transfer with in_last=1. In LOCK only the owner (ptr) SHALL be granted; other requesters wait even while the owner is invalid.
REQ-021 A simultaneous drain and fill (out_ready=1 and a transfer in the same cycle) SHALL give a back-to-back beat with no bubble.

Reset
REQ-022 rst=0 SHALL force out_valid=0, out_data=0, out_sel=0, ptr=3 (requester 0 gets first priority) and FSM=ARB.
REQ-023 rst=0 SHALL force in_ready=0. A reset mid-burst or mid-handshake SHALL discard the held beat and the lock; nothing is replayed.
REQ-024 The first grant SHALL be possible on the first rising edge after rst returns to 1.

Configuration
REQ-025 With macro MUX_ARB_LOCK_EN defined, the in_last port and the LOCK state SHALL be compiled in.
REQ-026 With MUX_ARB_LOCK_EN undefined, in_last SHALL be absent and arbitration SHALL be per-beat round-robin.

Structure
REQ-027 Package mux_arb_pkg SHALL hold N_REQ=4, SEL_W=2 and the FSM state enum (ARB, LOCK).
REQ-028 Sub-module rr_pick4 (combinational) SHALL take a 4-bit request vector and ptr, and return the grant index and a grant-valid flag.

Verification
REQ-029 Reset, then in_valid=4'b1111 with out_ready=1 held high -> grants in order 0,1,2,3,0; out_sel matches each grant one cycle later; no bubbles.
REQ-030 in_valid=4'b0100, in_data2=8'hA5, out_ready=0 -> out_valid=1 with out_data=8'hA5 and out_sel=2; in_ready=0 while held; data stable until out_ready=1.
REQ-031 ptr=3 and in_valid=4'b1000 only -> requester 3 granted (wrap search); then in_valid=4'b1001 -> requester 0 granted next.
REQ-032 With MUX_ARB_LOCK_EN defined: requester 1 sends 3 beats (in_last=0,0,1) while requester 2 is valid throughout -> requester 2 receives no grant until after the third beat, then is granted.
REQ-033 Assert rst=0 with out_valid=1 and in LOCK -> out_valid=0 and in_ready=0 immediately; after release, requester 0 has first priority.
REQ-034 Every cycle, assertions SHALL check: in_ready is one-hot or zero; out_data/out_sel are stable while out_valid&!out_ready; no transfer occurs while the register is not free.
